// File: rtl/tag_channel_filter_if.sv
// Tag stream bundle: one beat of up to WORD_WIDTH tags plus a per-beat
// lower time bound, moved with a valid/ready handshake.
interface tag_channel_filter_if #(
    parameter int WORD_WIDTH    = 4,
    parameter int TIME_WIDTH    = 64,
    parameter int CHANNEL_WIDTH = 6
);
    // A beat moves on any rising clk edge where tvalid and tready are both 1.
    // The master holds the beat stable while tvalid=1 and tready=0.
    // The slave may drive tready without waiting for tvalid.
    logic                                tvalid;
    logic                                tready;
    logic [WORD_WIDTH-1:0]               tkeep;
    logic [TIME_WIDTH*WORD_WIDTH-1:0]    tagtime;
    logic [CHANNEL_WIDTH*WORD_WIDTH-1:0] channel;
    logic [TIME_WIDTH-1:0]               lowest_time_bound;

    modport master (
        output tvalid, tkeep, tagtime, channel, lowest_time_bound,
        input  tready
    );

    modport slave (
        input  tvalid, tkeep, tagtime, channel, lowest_time_bound,
        output tready
    );
endinterface

// File: rtl/tag_channel_filter.sv
// Masks tag lanes by channel, counts masked tags, drops fully-masked beats
// (with a periodic empty heartbeat beat) behind a 2-entry skid buffer.
module tag_channel_filter #(
    parameter int WORD_WIDTH      = 4,
    parameter int TIME_WIDTH      = 64,
    parameter int CHANNEL_WIDTH   = 6,
    parameter int HEARTBEAT_BEATS = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    tag_channel_filter_if.slave         s,
    tag_channel_filter_if.master        m,
    input  logic [2**CHANNEL_WIDTH-1:0] channel_enable_i,
    input  logic                        clear_count_i,
    output logic [31:0]                 drop_count_o
);

    localparam int DW    = WORD_WIDTH * (1 + TIME_WIDTH + CHANNEL_WIDTH) + TIME_WIDTH;
    localparam int CNT_W = $clog2(WORD_WIDTH + 1);
    localparam int HB_W  = $clog2(HEARTBEAT_BEATS + 1);

    logic [DW-1:0]         out_beat_q, out_beat_d;
    logic [DW-1:0]         skid_beat_q, skid_beat_d;
    logic                  out_valid_q, out_valid_d;
    logic                  skid_valid_q, skid_valid_d;
    logic                  s_tready_q, s_tready_d;
    logic [HB_W-1:0]       hb_cnt_q, hb_cnt_d;
    logic [31:0]           drop_count_q, drop_count_d;

    logic [WORD_WIDTH-1:0] kept;
    logic [WORD_WIDTH-1:0] masked;
    logic [CNT_W-1:0]      masked_cnt;
    logic [32:0]           drop_sum;
    logic                  accept;
    logic                  heartbeat;
    logic                  fwd;
    logic                  out_free;
    logic [DW-1:0]         in_beat;

    always_comb begin
        kept       = '0;
        masked_cnt = '0;
        for (int i = 0; i < WORD_WIDTH; i++) begin
            kept[i] = s.tkeep[i] & channel_enable_i[s.channel[i*CHANNEL_WIDTH +: CHANNEL_WIDTH]];
        end
        masked = s.tkeep & ~kept;
        for (int i = 0; i < WORD_WIDTH; i++) begin
            masked_cnt = masked_cnt + CNT_W'(masked[i]);
        end

        accept    = s.tvalid & s_tready_q;
        heartbeat = (hb_cnt_q == HB_W'(HEARTBEAT_BEATS - 1));
        fwd       = accept & ((|kept) | heartbeat);
        in_beat   = {kept, s.tagtime, s.channel, s.lowest_time_bound};
        out_free  = ~out_valid_q | m.tready;
        drop_sum  = {1'b0, drop_count_q} + 33'(masked_cnt);

        out_beat_d   = out_beat_q;
        out_valid_d  = out_valid_q;
        skid_beat_d  = skid_beat_q;
        skid_valid_d = skid_valid_q;
        hb_cnt_d     = hb_cnt_q;
        drop_count_d = drop_count_q;

        // The skid entry is older than anything arriving now, so it refills
        // the output register first; s_tready is low whenever it is full.
        if (out_free) begin
            if (skid_valid_q) begin
                out_beat_d   = skid_beat_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end else begin
                out_valid_d = fwd;
                if (fwd) begin
                    out_beat_d = in_beat;
                end
            end
        end else if (fwd) begin
            skid_beat_d  = in_beat;
            skid_valid_d = 1'b1;
        end
        s_tready_d = ~skid_valid_d;

        if (accept) begin
            hb_cnt_d = fwd ? '0 : hb_cnt_q + HB_W'(1);
        end

        if (clear_count_i) begin
            drop_count_d = '0;
        end else if (accept) begin
            drop_count_d = drop_sum[32] ? '1 : drop_sum[31:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_beat_q   <= '0;
            out_valid_q  <= 1'b0;
            skid_beat_q  <= '0;
            skid_valid_q <= 1'b0;
            s_tready_q   <= 1'b0;
            hb_cnt_q     <= '0;
            drop_count_q <= '0;
        end else begin
            out_beat_q   <= out_beat_d;
            out_valid_q  <= out_valid_d;
            skid_beat_q  <= skid_beat_d;
            skid_valid_q <= skid_valid_d;
            s_tready_q   <= s_tready_d;
            hb_cnt_q     <= hb_cnt_d;
            drop_count_q <= drop_count_d;
        end
    end

    assign s.tready     = s_tready_q;
    assign m.tvalid     = out_valid_q;
    assign {m.tkeep, m.tagtime, m.channel, m.lowest_time_bound} = out_beat_q;
    assign drop_count_o = drop_count_q;

endmodule

// File: tb/tb_tag_channel_filter.sv
// Directed vector table, heartbeat/saturation/reset/mask-timing sequences and
// a random-backpressure run checked against an output scoreboard.
module tb_tag_channel_filter;

    localparam int W  = 4;
    localparam int T  = 64;
    localparam int C  = 6;
    localparam int HB = 16;
    localparam int DW = W + T*W + C*W + T;

    typedef logic [DW-1:0] beat_t;

    typedef struct {
        logic [W-1:0]   keep;
        logic [C*W-1:0] ch;
        logic [63:0]    en;
        logic           fwd;
        logic [W-1:0]   mkeep;
        logic [31:0]    drop;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] channel_enable;
    logic        clear_count;
    logic [31:0] drop_count;

    tag_channel_filter_if #(.WORD_WIDTH(W), .TIME_WIDTH(T), .CHANNEL_WIDTH(C)) s_if ();
    tag_channel_filter_if #(.WORD_WIDTH(W), .TIME_WIDTH(T), .CHANNEL_WIDTH(C)) m_if ();

    tag_channel_filter #(
        .WORD_WIDTH(W), .TIME_WIDTH(T), .CHANNEL_WIDTH(C), .HEARTBEAT_BEATS(HB)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .s                (s_if),
        .m                (m_if),
        .channel_enable_i (channel_enable),
        .clear_count_i    (clear_count),
        .drop_count_o     (drop_count)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    logic [DW-1:0] exp_q[$];
    logic [31:0] drop_model = '0;
    int          hb_model = 0;
    bit          after_rst = 1'b1;
    bit          v3_done = 1'b0;

    task automatic check(input string name, input beat_t act, input beat_t exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] model_kept(input logic [W-1:0] keep,
                                                input logic [C*W-1:0] ch,
                                                input logic [63:0] en);
        logic [W-1:0] k;
        logic [C-1:0] c;
        k = '0;
        for (int i = 0; i < W; i++) begin
            c    = ch[i*C +: C];
            k[i] = keep[i] & en[c];
        end
        return k;
    endfunction

    function automatic logic [C*W-1:0] ch4(input int a, input int b, input int c, input int d);
        return {C'(d), C'(c), C'(b), C'(a)};
    endfunction

    // Negedge monitor: output scoreboard, drop-count model, occupancy vs s_tready.
    always @(negedge clk) begin : monitor
        logic [W-1:0] k;
        logic [32:0]  sum;
        beat_t        act;
        if (rst) begin
            exp_q.delete();
            drop_model = '0;
            hb_model   = 0;
            after_rst  = 1'b1;
        end else begin
            check("drop_count_track", beat_t'(drop_count), beat_t'(drop_model));
            if (!after_rst)
                check("s_tready_vs_occupancy", beat_t'(s_if.tready), beat_t'(exp_q.size() < 2));
            after_rst = 1'b0;
            if (m_if.tvalid && m_if.tready) begin
                act = {m_if.tkeep, m_if.tagtime, m_if.channel, m_if.lowest_time_bound};
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sb_unexpected: got beat %0h expected none", act);
                end else begin
                    check("sb_beat", act, exp_q.pop_front());
                end
            end
            if (s_if.tvalid && s_if.tready) begin
                k = model_kept(s_if.tkeep, s_if.channel, channel_enable);
                if (k != '0 || hb_model == HB - 1) begin
                    exp_q.push_back({k, s_if.tagtime, s_if.channel, s_if.lowest_time_bound});
                    hb_model = 0;
                end else begin
                    hb_model++;
                end
                sum = {1'b0, drop_model} + 33'($countones(s_if.tkeep & ~k));
                if (clear_count) drop_model = '0;
                else             drop_model = sum[32] ? 32'hFFFF_FFFF : sum[31:0];
            end else if (clear_count) begin
                drop_model = '0;
            end
        end
    end

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic set_beat(input logic [W-1:0] keep, input logic [C*W-1:0] ch, input logic [63:0] en);
        s_if.tvalid  = 1'b1;
        s_if.tkeep   = keep;
        s_if.channel = ch;
        channel_enable = en;
        for (int i = 0; i < 8; i++) s_if.tagtime[i*32 +: 32] = $urandom;
        s_if.lowest_time_bound = {$urandom, $urandom};
    endtask

    // Presents a beat and returns just after the edge that accepts it.
    task automatic drive_beat(input logic [W-1:0] keep, input logic [C*W-1:0] ch,
                              input logic [63:0] en, output int stalls);
        set_beat(keep, ch, en);
        stalls = 0;
        @(negedge clk);
        while (!s_if.tready && stalls < 200) begin
            stalls++;
            @(negedge clk);
        end
        if (!s_if.tready) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: got s_tready=0 after %0d cycles expected 1", stalls);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        s_if.tvalid = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    vec_t        vecs[8];
    int          stalls;
    int          stall_sum;
    logic [T*W-1:0] tt;
    logic [T-1:0]   lt;
    logic [63:0]    en_r;
    int             sel;

    initial begin
        vecs[0] = '{4'b1111, ch4(1, 2, 3, 4),   64'h0A,                  1'b1, 4'b0101, 32'd2};
        vecs[1] = '{4'b1111, ch4(0, 0, 0, 0),   64'h1,                   1'b1, 4'b1111, 32'd2};
        vecs[2] = '{4'b1010, ch4(0, 5, 62, 63), 64'h8000_0000_0000_0020, 1'b1, 4'b1010, 32'd2};
        vecs[3] = '{4'b0110, ch4(7, 8, 9, 10),  64'h100,                 1'b1, 4'b0010, 32'd3};
        vecs[4] = '{4'b1111, ch4(1, 2, 3, 4),   64'h0,                   1'b0, 4'b0000, 32'd7};
        vecs[5] = '{4'b0000, ch4(1, 2, 3, 4),   64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 4'b0000, 32'd7};
        vecs[6] = '{4'b0001, ch4(2, 9, 9, 9),   64'h4,                   1'b1, 4'b0001, 32'd7};
        vecs[7] = '{4'b1100, ch4(0, 0, 33, 40), 64'h0000_0102_0000_0000, 1'b1, 4'b1100, 32'd7};

        rst = 1'b1;
        s_if.tvalid = 1'b0;
        s_if.tkeep = '0;
        s_if.tagtime = '0;
        s_if.channel = '0;
        s_if.lowest_time_bound = '0;
        m_if.tready = 1'b1;
        channel_enable = '0;
        clear_count = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_m_tvalid", beat_t'(m_if.tvalid), beat_t'(0));
        check("rst_s_tready", beat_t'(s_if.tready), beat_t'(0));
        check("rst_drop_count", beat_t'(drop_count), beat_t'(0));
        sync();
        @(negedge clk);
        check("post_rst_s_tready", beat_t'(s_if.tready), beat_t'(1));
        sync();

        // Vector table, one beat at a time with the output free.
        for (int i = 0; i < 8; i++) begin
            drive_beat(vecs[i].keep, vecs[i].ch, vecs[i].en, stalls);
            tt = s_if.tagtime;
            lt = s_if.lowest_time_bound;
            idle();
            @(negedge clk);
            check($sformatf("vec%0d_m_tvalid", i), beat_t'(m_if.tvalid), beat_t'(vecs[i].fwd));
            if (vecs[i].fwd) begin
                check($sformatf("vec%0d_m_tkeep", i), beat_t'(m_if.tkeep), beat_t'(vecs[i].mkeep));
                check($sformatf("vec%0d_m_tagtime", i), beat_t'(m_if.tagtime), beat_t'(tt));
                check($sformatf("vec%0d_m_channel", i), beat_t'(m_if.channel), beat_t'(vecs[i].ch));
                check($sformatf("vec%0d_m_ltb", i), beat_t'(m_if.lowest_time_bound), beat_t'(lt));
            end
            check($sformatf("vec%0d_drop_count", i), beat_t'(drop_count), beat_t'(vecs[i].drop));
            sync();
        end

        // Heartbeat: 15 silent drops, the 16th emerges empty, the 17th drops again.
        for (int i = 1; i <= 17; i++) begin
            drive_beat(4'b1111, ch4(1, 2, 3, 4), 64'h0, stalls);
            lt = s_if.lowest_time_bound;
            idle();
            @(negedge clk);
            check($sformatf("hb_beat%0d_m_tvalid", i), beat_t'(m_if.tvalid), beat_t'(i == 16));
            if (i == 16) begin
                check("hb_m_tkeep", beat_t'(m_if.tkeep), beat_t'(0));
                check("hb_m_ltb", beat_t'(m_if.lowest_time_bound), beat_t'(lt));
            end
            sync();
        end
        check("hb_drop_count", beat_t'(drop_count), beat_t'(32'd75));

        // Back-to-back with the output always ready: one beat every cycle.
        stall_sum = 0;
        for (int i = 0; i < 20; i++) begin
            drive_beat(4'(i), 24'($urandom), 64'hFFFF_FFFF_FFFF_FFFF, stalls);
            stall_sum += stalls;
        end
        idle();
        check("stream_stalls", beat_t'(stall_sum), beat_t'(0));
        repeat (4) sync();

        // Random backpressure run.
        fork
            begin
                for (int i = 0; i < 1000; i++) begin
                    sel = $urandom_range(0, 7);
                    if (sel == 0)      en_r = {$urandom, $urandom};
                    else if (sel == 1) en_r = '1;
                    else               en_r = '0;
                    drive_beat(4'($urandom_range(0, 15)), 24'($urandom), en_r, stalls);
                end
                idle();
                v3_done = 1'b1;
            end
            begin
                while (!v3_done) begin
                    m_if.tready = 1'($urandom_range(0, 1));
                    sync();
                end
            end
        join
        m_if.tready = 1'b1;
        repeat (6) sync();
        check("random_drain", beat_t'(exp_q.size()), beat_t'(0));

        // Saturation and clear priority.
        force dut.drop_count_q = 32'hFFFF_FFFE;
        #1;
        release dut.drop_count_q;
        drop_model = 32'hFFFF_FFFE;
        drive_beat(4'b1111, ch4(0, 1, 2, 3), 64'h1, stalls);
        idle();
        @(negedge clk);
        check("sat_reach", beat_t'(drop_count), beat_t'(32'hFFFF_FFFF));
        sync();
        drive_beat(4'b1111, ch4(0, 1, 2, 3), 64'h1, stalls);
        idle();
        @(negedge clk);
        check("sat_hold", beat_t'(drop_count), beat_t'(32'hFFFF_FFFF));
        sync();
        clear_count = 1'b1;
        drive_beat(4'b1111, ch4(0, 1, 2, 3), 64'h1, stalls);
        clear_count = 1'b0;
        idle();
        @(negedge clk);
        check("clear_wins", beat_t'(drop_count), beat_t'(0));
        sync();
        drive_beat(4'b1111, ch4(0, 1, 2, 3), 64'h1, stalls);
        idle();
        @(negedge clk);
        check("count_after_clear", beat_t'(drop_count), beat_t'(3));
        sync();
        repeat (3) sync();

        // Reset with two beats buffered under backpressure.
        m_if.tready = 1'b0;
        drive_beat(4'b1111, ch4(1, 2, 3, 4), '1, stalls);
        drive_beat(4'b0011, ch4(1, 2, 3, 4), '1, stalls);
        idle();
        @(negedge clk);
        check("pre_rst_s_tready", beat_t'(s_if.tready), beat_t'(0));
        check("pre_rst_m_tvalid", beat_t'(m_if.tvalid), beat_t'(1));
        sync();
        rst = 1'b1;
        sync();
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_m_tvalid", beat_t'(m_if.tvalid), beat_t'(0));
        sync();
        m_if.tready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("mid_rst_quiet%0d", i), beat_t'(m_if.tvalid), beat_t'(0));
            sync();
        end
        check("mid_rst_s_tready", beat_t'(s_if.tready), beat_t'(1));

        // Mask change in the accept cycle of the second of two held beats.
        m_if.tready = 1'b0;
        drive_beat(4'b1111, ch4(0, 1, 2, 3), 64'h3, stalls);
        tt = s_if.tagtime;
        drive_beat(4'b1111, ch4(0, 1, 2, 3), 64'hC, stalls);
        idle();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("mask_old_tvalid%0d", i), beat_t'(m_if.tvalid), beat_t'(1));
            check($sformatf("mask_old_tkeep%0d", i), beat_t'(m_if.tkeep), beat_t'(4'b0011));
            check($sformatf("mask_old_tagtime%0d", i), beat_t'(m_if.tagtime), beat_t'(tt));
            sync();
        end
        m_if.tready = 1'b1;
        sync();
        @(negedge clk);
        check("mask_new_tvalid", beat_t'(m_if.tvalid), beat_t'(1));
        check("mask_new_tkeep", beat_t'(m_if.tkeep), beat_t'(4'b1100));
        sync();
        repeat (4) sync();
        check("final_drain", beat_t'(exp_q.size()), beat_t'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tag_channel_filter.md
TAG_CHANNEL_FILTER -- requirements
Module: tag_channel_filter

Interface
REQ-001 SHALL have parameter WORD_WIDTH, default 4, number of tag lanes per beat.
REQ-002 SHALL have parameter TIME_WIDTH, default 64, tag time width in bits.
REQ-003 SHALL have parameter CHANNEL_WIDTH, default 6, channel index width in bits.
REQ-004 SHALL have parameter HEARTBEAT_BEATS, default 16, the count of consecutive dropped input beats that forces an empty output beat.
REQ-005 SHALL use one clock and a synchronous, active-high reset, with ports clk (in, 1, clock) and rst (in, 1, synchronous active-high reset).
REQ-006 SHALL have s_tvalid (in, 1) and s_tready (out, 1) as the upstream handshake.
REQ-007 SHALL have s_tkeep (in, WORD_WIDTH) giving per-lane tag valid.
REQ-008 SHALL have s_tagtime (in, TIME_WIDTH*WORD_WIDTH) carrying packed tag times, with lane i at bits [i*TIME_WIDTH +: TIME_WIDTH].
REQ-009 SHALL have s_channel (in, CHANNEL_WIDTH*WORD_WIDTH) carrying packed channels, with lane i at bits [i*CHANNEL_WIDTH +: CHANNEL_WIDTH].
REQ-010 SHALL have s_lowest_time_bound (in, TIME_WIDTH), a time lower bound for the beat.
REQ-011 SHALL have m_tvalid (out, 1), m_tready (in, 1), m_tkeep, m_tagtime, m_channel and m_lowest_time_bound, mirroring the s_ ports in width.
REQ-012 SHALL have channel_enable_i (in, 2**CHANNEL_WIDTH), a per-channel pass mask where bit n=1 passes channel n.
REQ-013 SHALL have clear_count_i (in, 1), a synchronous clear of drop_count_o.
REQ-014 SHALL have drop_count_o (out, 32), the saturating count of masked-out tags.

Function
REQ-015 SHALL accept an input beat when s_tvalid and s_tready are both 1 in the same cycle.
REQ-016 SHALL compute the masked keep per lane as kept[i] = s_tkeep[i] AND channel_enable_i[s_channel lane i], sampling channel_enable_i in the accept cycle.
REQ-017 SHALL forward an accepted beat with any kept bit set, carrying m_tkeep = kept with tagtime, channel and lowest_time_bound unchanged.
REQ-018 SHALL discard an accepted beat with kept all zero, and SHALL increment the dropped-beat counter for it.
REQ-019 SHALL forward an all-zero-kept beat with m_tkeep = 0 (a heartbeat) when the dropped-beat counter is HEARTBEAT_BEATS-1 at accept, and SHALL clear the dropped-beat counter on that beat.
REQ-020 SHALL clear the dropped-beat counter on every forwarded non-empty beat.
REQ-021 SHALL present a forwarded beat on m_* exactly 1 cycle after accept when the output is not stalled.
REQ-022 SHALL use a 2-entry skid buffer (output register plus skid register).
REQ-023 SHALL drive s_tready from a register, deasserting it only when the skid register is full.
REQ-024 SHALL sustain 1 beat per cycle while m_tready is held at 1.
REQ-025 SHALL hold m_* stable while m_tvalid=1 and m_tready=0 (AXI-Stream stability rule).
REQ-026 SHALL NOT drop a forwarded beat on backpressure; at most 2 beats may be in flight.
REQ-027 SHALL NOT reorder beats.
REQ-028 SHALL NOT modify tagtime, channel or lowest_time_bound of masked lanes; only m_tkeep is affected.
REQ-029 SHALL increase drop_count_o by popcount(s_tkeep AND NOT kept) on each accepted beat, saturating at 2**32-1.
REQ-030 SHALL set drop_count_o to 0 when clear_count_i=1, with clear winning over a same-cycle increment (that increment is lost).
REQ-031 SHALL apply a channel_enable_i change beginning with the first beat accepted after the change; beats already in flight are unaffected.
REQ-032 SHALL accept a beat with s_tkeep=0: it counts as a dropped beat with no increment to drop_count_o.
REQ-033 SHALL forward a beat accepted while the skid buffer drains in the same cycle without loss or duplication.

Reset
REQ-034 SHALL, on rst=1, set m_tvalid=0, s_tready=0, drop_count_o=0, the dropped-beat counter to 0, and both buffer entries to empty.
REQ-035 SHALL drive s_tready=1 in the first cycle after rst deasserts.
REQ-036 SHALL discard in-flight beats on mid-operation rst; no beat accepted before rst appears after it.

Verification
REQ-037 SHALL pass test V1: WORD_WIDTH=4, enable={ch1,ch3}, one beat with channels 1,2,3,4 and keep=1111 -> 1 cycle later m_tkeep=0101, drop_count_o=2.
REQ-038 SHALL pass test V2: 15 beats with all channels disabled, then a 16th -> no output for beats 1-15; beat 16 is output with m_tkeep=0 and its lowest_time_bound; the counter restarts.
REQ-039 SHALL pass test V3: continuous s_tvalid with m_tready toggling randomly over 1000 beats -> output sequence equals reference-model sequence; s_tready never low while the skid is empty.
REQ-040 SHALL pass test V4: drop_count_o preloaded to 2**32-2 by forcing, then a beat with 3 masked tags -> 2**32-1 and holds; clear_count_i together with an increment -> 0.
REQ-041 SHALL pass test V5: rst asserted for 1 cycle with 2 beats buffered and m_tready=0 -> m_tvalid=0 the next cycle; neither beat ever emitted.
REQ-042 SHALL pass test V6: enable mask changed in the same cycle as an accept -> that beat uses the new mask; the previous in-flight beat keeps the old mask.
